// File: rtl/angle_normalizer.sv
// Reduces a signed whole-degree angle into 0..FULL_TURN-1, one correction per clock.
// Define ANGLE_NORM_COS_EN to add out_cos_angle, the result advanced by a quarter turn.
module angle_normalizer #(
    parameter int W         = 16,
    parameter int FULL_TURN = 360
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_angle,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_angle,
`ifdef ANGLE_NORM_COS_EN
    output logic [W-1:0] out_cos_angle,
`endif
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        DONE
    } state_t;

    localparam logic signed [W:0] TURN_S = FULL_TURN[W:0];

    state_t              state_q;
    // One extra bit so that +/-FULL_TURN steps never overflow, even from the most negative input.
    logic signed [W:0]   work_q;
    logic signed [W:0]   work_d;
    logic                in_range;
    logic                out_valid_q;
    logic [W-1:0]        out_angle_q;

    always_comb begin
        work_d   = work_q;
        in_range = 1'b0;
        if (work_q[W]) begin
            work_d = work_q + TURN_S;
        end else if (work_q >= TURN_S) begin
            work_d = work_q - TURN_S;
        end else begin
            in_range = 1'b1;
        end
    end

`ifdef ANGLE_NORM_COS_EN
    localparam int           QTR    = 90;
    localparam logic [W-1:0] QTR_U  = QTR[W-1:0];
    localparam logic [W-1:0] TURN_U = FULL_TURN[W-1:0];

    logic [W-1:0] cos_d;
    logic [W-1:0] cos_q;

    always_comb begin
        cos_d = work_q[W-1:0] + QTR_U;
        if (cos_d >= TURN_U) begin
            cos_d = cos_d - TURN_U;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cos_q <= QTR_U;
        end else if (state_q == REDUCE && in_range) begin
            cos_q <= cos_d;
        end
    end

    assign out_cos_angle = cos_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            out_angle_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q  <= {in_angle[W-1], in_angle};
                        state_q <= REDUCE;
                    end
                end
                REDUCE: begin
                    work_q <= work_d;
                    if (in_range) begin
                        out_angle_q <= work_q[W-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_angle = out_angle_q;

endmodule

// File: tb/tb_angle_normalizer.sv
// Self-checking bench for angle_normalizer: directed boundaries plus random angles
// compared against an arithmetic modulo model.
module tb_angle_normalizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_angle = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_angle;
    logic        busy;
`ifdef ANGLE_NORM_COS_EN
    logic [15:0] out_cos_angle;
`endif

    int checks = 0;
    int errors = 0;

    angle_normalizer #(.W(16), .FULL_TURN(360)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_angle  (in_angle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_angle (out_angle),
`ifdef ANGLE_NORM_COS_EN
        .out_cos_angle (out_cos_angle),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int ref_norm(input int a);
        return ((a % 360) + 360) % 360;
    endfunction

    function automatic int ref_steps(input int a);
        if (a < 0) return (-a + 359) / 360;
        return a / 360;
    endfunction

    function automatic int ref_cos(input int a);
        return (ref_norm(a) + 90) % 360;
    endfunction

    // Starts at posedge+1 in IDLE; returns observations, ends at posedge+1 after consume.
    task automatic run_op(input int a, output int lat, output logic [15:0] res,
                          output logic [15:0] cres, output bit rdy_seen);
        logic [15:0] a16;
        a16 = a[15:0];
        out_ready = 1'b1;
        in_angle  = a16;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_angle = 16'($urandom);
        lat = 0;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        res = out_angle;
`ifdef ANGLE_NORM_COS_EN
        cres = out_cos_angle;
`else
        cres = '0;
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_angle = 16'($urandom);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || out_angle !== 16'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_state got v=%b a=%0d b=%b r=%b want v=0 a=0 b=0 r=1",
                         out_valid, out_angle, busy, in_ready);
            end
`ifdef ANGLE_NORM_COS_EN
            checks++;
            if (out_cos_angle !== 16'd90) begin
                errors++;
                $display("FAIL reset_cos got %0d want 90", out_cos_angle);
            end
`endif
        end
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle got b=%b r=%b want b=0 r=1", busy, in_ready);
        end
    endtask

    task automatic check_vec(input string name, input int vals[$], input bit want_no_rdy);
        int lat;
        logic [15:0] r, c;
        bit rs;
        int e;
        foreach (vals[i]) begin
            run_op(vals[i], lat, r, c, rs);
            e = ref_norm(vals[i]);
            checks++;
            if (r !== e[15:0]) begin
                errors++;
                $display("FAIL %s_angle in=%0d got %0d want %0d", name, vals[i], r, e);
            end
            checks++;
            if (lat != 1 + ref_steps(vals[i])) begin
                errors++;
                $display("FAIL %s_latency in=%0d got %0d want %0d", name, vals[i], lat,
                         1 + ref_steps(vals[i]));
            end
            if (want_no_rdy) begin
                checks++;
                if (rs) begin
                    errors++;
                    $display("FAIL %s_in_ready in=%0d got 1 want 0", name, vals[i]);
                end
            end
`ifdef ANGLE_NORM_COS_EN
            e = ref_cos(vals[i]);
            checks++;
            if (c !== e[15:0]) begin
                errors++;
                $display("FAIL %s_cos in=%0d got %0d want %0d", name, vals[i], c, e);
            end
`endif
        end
    endtask

    task automatic test_in_range();
        check_vec("in_range", '{30, 0, 359}, 1'b1);
    endtask

    task automatic test_wrap();
        check_vec("wrap", '{390, 360, 300}, 1'b1);
    endtask

    task automatic test_negative();
        check_vec("negative", '{-30, -1, -360}, 1'b1);
    endtask

    task automatic test_extremes();
        check_vec("extreme", '{32767, -32768}, 1'b1);
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        in_angle  = 16'd150;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL bp_latency got %0d want 1", n);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_angle = 16'($urandom);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_angle !== 16'd150 || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got v=%b a=%0d r=%b b=%b want v=1 a=150 r=0 b=1",
                         i, out_valid, out_angle, in_ready, busy);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_angle !== 16'd150) begin
            errors++;
            $display("FAIL bp_release got v=%b r=%b b=%b a=%0d want v=0 r=1 b=0 a=150",
                     out_valid, in_ready, busy, out_angle);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_ghost got b=%b v=%b want b=0 v=0", busy, out_valid);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [15:0] r, c;
        bit rs;
        out_ready = 1'b1;
        in_angle  = 16'd32767;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_angle !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_state got v=%b r=%b a=%0d b=%b want v=0 r=1 a=0 b=0",
                     out_valid, in_ready, out_angle, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_pulse got v=%b b=%b want v=0 b=0", out_valid, busy);
        end
        run_op(200, lat, r, c, rs);
        checks++;
        if (r !== 16'd200 || lat != 1) begin
            errors++;
            $display("FAIL abort_next got a=%0d lat=%0d want a=200 lat=1", r, lat);
        end
    endtask

    task automatic test_random();
        int lat, a, e;
        logic [15:0] r, c;
        bit rs;
        for (int i = 0; i < 40; i++) begin
            a = int'($signed(16'($urandom)));
            run_op(a, lat, r, c, rs);
            e = ref_norm(a);
            checks++;
            if (r !== e[15:0] || lat != 1 + ref_steps(a) || rs) begin
                errors++;
                $display("FAIL random in=%0d got a=%0d lat=%0d rdy=%b want a=%0d lat=%0d rdy=0",
                         a, r, lat, rs, e, 1 + ref_steps(a));
            end
`ifdef ANGLE_NORM_COS_EN
            e = ref_cos(a);
            checks++;
            if (c !== e[15:0]) begin
                errors++;
                $display("FAIL random_cos in=%0d got %0d want %0d", a, c, e);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_in_range();
        test_wrap();
        test_negative();
        test_extremes();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
